async_reset_pipe: RTL and testbench
===================================

# async_reset_pipe

Parametrised, multi-bit, multi-stage register pipeline in which every flop is asynchronously reset to a per-bit reset value. It carries its own reset-deassertion synchronizer, so the pipeline leaves reset cleanly on a `clk` edge. An occupancy counter flags when the output holds genuine post-reset data. It serves as the general building block for crossing-adjacent status and control paths that must reach a defined value the instant `rst` asserts, whether or not `clk` is running.

## Interface
Parameters:
- WIDTH, 1: data width in bits; must be ≥1.
- DEPTH, 3: number of data pipeline stages; must be ≥1.
- RESET_VALUE, 0: WIDTH-bit value loaded into every data stage on reset.
- SYNC_STAGES, 2: length of the reset-deassertion synchronizer; must be ≥2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: shift enable.
- d, input, WIDTH: data into stage 0.
- q, output, WIDTH: last data stage.
- q_valid, output, 1: high once q holds data that was sampled after reset.
- rst_sync, output, 1: internal reset; asserts asynchronously and deasserts synchronously.

## Operation
Reset:
- While rst=1, every data stage = RESET_VALUE, every sync flop = 1, fill counter = 0.
- So on reset: q=RESET_VALUE, q_valid=0, rst_sync=1.

Synchronizer:
- Shift chain with 0 shifted in each clk edge; rst_sync is the last flop.
- rst_sync falls on the SYNC_STAGES-th rising edge after rst falls.

While rst_sync=1:
- Data stages hold RESET_VALUE; en is ignored; counter stays 0.

While rst_sync=0 and en=1, at each rising edge:
- stage0 <= d.
- stage[i] <= stage[i-1] for i = 1..DEPTH-1.
- Counter increments, saturating at DEPTH.

While rst_sync=0 and en=0:
- All stages and the counter hold.

Counter and q_valid:
- Counter width is clog2(DEPTH+1).
- q_valid is registered: it is 1 exactly when counter == DEPTH.
- Once high, q_valid stays high until the next rst.

Reset mid-operation:
- rst rising at any time clears all state immediately, with no clk edge needed.
- In-flight data is discarded; q_valid drops in the same instant.

rst glitches:
- A rst pulse shorter than one clk period still clears all state.
- A pulse shorter than one clk period also restarts the full SYNC_STAGES deassertion count.

## Timing
Latency:
- d sampled at enabled edge k appears on q after DEPTH enabled edges. With en held high, that is edge k+DEPTH-1, counting the sampling edge as the first.
- en gaps stretch the latency by the number of disabled cycles.

q_valid:
- Rises on the same edge at which q first shows the first post-reset sample.

Start-up from rst falling:
- The first d sample is taken on edge SYNC_STAGES+1 after rst falls, provided en=1.
- rst_sync=1 during the edge where it falls blocks that edge from shifting.

Reset paths:
- Assertion is asynchronous: all outputs take their reset values combinationally from rst.
- No combinational path from d or en to q or q_valid.

## Structure
Package async_reset_pkg:
- Constant ASYNC_RESET_MIN_SYNC_STAGES = 2.
- Counter-width function: clog2(n+1).
- Parameter range checks raise elaboration errors for: WIDTH<1, DEPTH<1, SYNC_STAGES<2.

Sub-module async_reset_reg_vec:
- One WIDTH-wide enabled register with an async reset to RESET_VALUE.
- Instantiated DEPTH times for the data stages.
- Also instantiated SYNC_STAGES times with WIDTH=1, RESET_VALUE=1, en=1 for the synchronizer.
- The counter is inline logic in async_reset_pipe.

## Test plan
- **Reset values:** WIDTH=8, RESET_VALUE=8'hA5, DEPTH=3, rst held high with clk stopped → q=8'hA5, q_valid=0, rst_sync=1. Must hold before any clk edge.
- **Sync deassert:** SYNC_STAGES=3, drop rst mid-cycle → rst_sync falls on the 3rd rising edge; d=8'h11 with en=1 is first captured on edge 4.
- **Latency and q_valid:** en=1 continuously, d = 1, 2, 3, 4… on successive edges after release → q=1 and q_valid=1 together, 2 edges after 1 is captured; then 2, 3, 4 on the following edges.
- **Enable gaps:** en pattern 1,0,0,1,1 with d=7,x,x,8,9 → q=7 and q_valid=1 only on the 5th edge; q and q_valid hold across the gap.
- **Reset mid-operation:** with q_valid=1 and q=8'h3C, pulse rst for 0.3 clk period → q=8'hA5 and q_valid=0 immediately; rst_sync=1 and the SYNC_STAGES count restarts.
- **Minimum configuration:** DEPTH=1, SYNC_STAGES=2, WIDTH=1, RESET_VALUE=1 → q=1 in reset; first enabled post-release d=0 gives q=0 and q_valid=1 on that same edge.

Source files
------------

// File: rtl/async_reset_pkg.sv
// Shared constants, counter sizing helper and parameter limits for async_reset_pipe.
package async_reset_pkg;

    localparam int unsigned ASYNC_RESET_MIN_SYNC_STAGES = 2;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/async_reset_reg_vec.sv
// Enabled WIDTH-bit register with asynchronous active-high reset to RESET_VALUE.
module async_reset_reg_vec #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/async_reset_pipe.sv
// Multi-stage data pipeline with async reset, reset-release synchronizer and
// an occupancy counter that flags when q carries post-reset data.
module async_reset_pipe
    import async_reset_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      DEPTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             rst_sync
);

    localparam int unsigned CW = cnt_width(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $error("async_reset_pipe: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("async_reset_pipe: DEPTH must be >= 1");
    end
    if (SYNC_STAGES < ASYNC_RESET_MIN_SYNC_STAGES) begin : g_bad_sync
        $error("async_reset_pipe: SYNC_STAGES must be >= 2");
    end

    // Reset-release synchronizer: zeros ripple in, last flop is rst_sync.
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] sync_in;

    assign sync_in  = {sync[SYNC_STAGES-2:0], 1'b0};
    assign rst_sync = sync[SYNC_STAGES-1];

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        async_reset_reg_vec #(
            .WIDTH       (1),
            .RESET_VALUE (1'b1)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .en  (1'b1),
            .d   (sync_in[i]),
            .q   (sync[i])
        );
    end

    // Data stages shift only once the synchronized reset has released.
    logic             shift;
    logic [WIDTH-1:0] stage [DEPTH];

    assign shift = en & ~rst_sync;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (i == 0) begin : g_first
            assign stage_in = d;
        end else begin : g_rest
            assign stage_in = stage[i-1];
        end

        async_reset_reg_vec #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (shift),
            .d   (stage_in),
            .q   (stage[i])
        );
    end

    assign q = stage[DEPTH-1];

    // Fill counter saturates at DEPTH; q_valid tracks the post-edge count.
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next_c;

    always_comb begin
        cnt_next_c = cnt;
        if (shift && (cnt != CW'(DEPTH))) begin
            cnt_next_c = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            q_valid <= 1'b0;
        end else begin
            cnt     <= cnt_next_c;
            q_valid <= (cnt_next_c == CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_async_reset_pipe.sv
// Directed bench for async_reset_pipe: a WIDTH=8/DEPTH=3/SYNC=3 instance and a
// minimum WIDTH=1/DEPTH=1/SYNC=2 instance share one gated clock.
module tb_async_reset_pipe;

    logic       clk;
    logic       clk_run;

    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [7:0] q;
    logic       q_valid;
    logic       rst_sync;

    logic       rst_m;
    logic       en_m;
    logic [0:0] d_m;
    logic [0:0] q_m;
    logic       q_valid_m;
    logic       rst_sync_m;

    int errors = 0;
    int checks = 0;

    async_reset_pipe #(
        .WIDTH       (8),
        .DEPTH       (3),
        .RESET_VALUE (8'hA5),
        .SYNC_STAGES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d        (d),
        .q        (q),
        .q_valid  (q_valid),
        .rst_sync (rst_sync)
    );

    async_reset_pipe #(
        .WIDTH       (1),
        .DEPTH       (1),
        .RESET_VALUE (1'b1),
        .SYNC_STAGES (2)
    ) dut_min (
        .clk      (clk),
        .rst      (rst_m),
        .en       (en_m),
        .d        (d_m),
        .q        (q_m),
        .q_valid  (q_valid_m),
        .rst_sync (rst_sync_m)
    );

    // Clock stays low until clk_run is set, so reset can be checked edge-free.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk_run = 1'b0;
        rst   = 1'b1; en   = 1'b0; d   = 8'h00;
        rst_m = 1'b1; en_m = 1'b0; d_m = 1'b0;

        // Reset values with clk stopped
        #20;
        chk("rst_q",         q,                  8'hA5);
        chk("rst_q_valid",   8'(q_valid),        8'h00);
        chk("rst_rst_sync",  8'(rst_sync),       8'h01);
        chk("min_rst_q",     8'(q_m),            8'h01);
        chk("min_rst_valid", 8'(q_valid_m),      8'h00);

        clk_run = 1'b1;
        edge_step();
        edge_step();

        // Release mid-cycle; edges counted from here
        #3 rst = 1'b0;
        en = 1'b1; d = 8'h11;
        edge_step();                               // edge 1
        chk("sync_e1", 8'(rst_sync), 8'h01);
        chk("sync_e1_q", q, 8'hA5);
        edge_step();                               // edge 2
        chk("sync_e2", 8'(rst_sync), 8'h01);
        edge_step();                               // edge 3: rst_sync falls, shift blocked
        chk("sync_e3", 8'(rst_sync), 8'h00);
        chk("sync_e3_q", q, 8'hA5);
        chk("sync_e3_valid", 8'(q_valid), 8'h00);
        edge_step();                               // edge 4: captures 11
        d = 8'h01;
        edge_step();                               // edge 5: captures 01
        chk("lat_e5_valid", 8'(q_valid), 8'h00);
        d = 8'h02;
        edge_step();                               // edge 6: q=11
        chk("lat_e6_q", q, 8'h11);
        chk("lat_e6_valid", 8'(q_valid), 8'h01);
        d = 8'h03;
        edge_step();
        chk("lat_e7_q", q, 8'h01);
        d = 8'h04;
        edge_step();
        chk("lat_e8_q", q, 8'h02);
        d = 8'h3C;
        edge_step();
        chk("lat_e9_q", q, 8'h03);
        edge_step();
        chk("lat_e10_q", q, 8'h04);
        edge_step();
        chk("lat_e11_q", q, 8'h3C);
        en = 1'b0; d = 8'h55;
        edge_step();
        chk("hold_q", q, 8'h3C);
        chk("hold_valid", 8'(q_valid), 8'h01);

        // 3-unit rst pulse (0.3 period), no clk edge inside it
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q", q, 8'hA5);
        chk("mid_rst_valid", 8'(q_valid), 8'h00);
        chk("mid_rst_sync", 8'(rst_sync), 8'h01);
        #2 rst = 1'b0;
        en = 1'b1; d = 8'h07;
        edge_step();
        chk("restart_e1", 8'(rst_sync), 8'h01);
        edge_step();
        chk("restart_e2", 8'(rst_sync), 8'h01);
        edge_step();                               // release edge, shift blocked
        chk("restart_e3", 8'(rst_sync), 8'h00);
        chk("restart_e3_q", q, 8'hA5);

        // Enable gap pattern 1,0,0,1,1 with d = 7,-,-,8,9
        edge_step();                               // G1 captures 7
        chk("gap_g1_q", q, 8'hA5);
        en = 1'b0; d = 8'hFF;
        edge_step();                               // G2
        edge_step();                               // G3
        chk("gap_g3_q", q, 8'hA5);
        chk("gap_g3_valid", 8'(q_valid), 8'h00);
        en = 1'b1; d = 8'h08;
        edge_step();                               // G4
        chk("gap_g4_q", q, 8'hA5);
        chk("gap_g4_valid", 8'(q_valid), 8'h00);
        d = 8'h09;
        edge_step();                               // G5
        chk("gap_g5_q", q, 8'h07);
        chk("gap_g5_valid", 8'(q_valid), 8'h01);

        // Minimum configuration: release mid-cycle, d=0
        #3 rst_m = 1'b0;
        en_m = 1'b1; d_m = 1'b0;
        edge_step();
        chk("min_e1_sync", 8'(rst_sync_m), 8'h01);
        edge_step();
        chk("min_e2_sync", 8'(rst_sync_m), 8'h00);
        chk("min_e2_q", 8'(q_m), 8'h01);
        chk("min_e2_valid", 8'(q_valid_m), 8'h00);
        edge_step();
        chk("min_e3_q", 8'(q_m), 8'h00);
        chk("min_e3_valid", 8'(q_valid_m), 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
